// File: rtl/fifo_stream_reader.sv
// Read-side adapter for a standard FIFO. It issues pops and captures the
// returned words into a two-entry skid buffer. The head of that buffer is
// presented as a valid/ready stream.
// Handles FIFOs with registered read data (READ_LATENCY=1) and with
// show-ahead read data (READ_LATENCY=0). It sustains one word per cycle.
module fifo_stream_reader #(
    parameter int WIDTH        = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_fifo_empty,
    output logic             o_fifo_pop,
    input  logic [WIDTH-1:0] i_fifo_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_level
);

    if (READ_LATENCY != 0 && READ_LATENCY != 1) begin : g_bad_latency
        $error("fifo_stream_reader: READ_LATENCY must be 0 or 1");
    end

    logic [WIDTH-1:0] buf_mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             inflight;
    logic             fire;
    logic             capture;
    logic [2:0]       occupancy;

    assign fire = o_valid & i_ready;

    // Words committed to the buffer after this edge: the words held now, plus
    // a word that is already on its way back, minus the word leaving now.
    // A pop is allowed only while that total leaves a free slot, so the
    // buffer can never overflow.
    always_comb begin
        occupancy  = {1'b0, count} + {2'b00, inflight} - {2'b00, fire};
        o_fifo_pop = i_rst_n & ~i_fifo_empty & ~i_clear & (occupancy < 3'd2);
    end

    // Show-ahead data lands in the pop cycle itself; registered data lands one
    // cycle later, marked by the inflight flag.
    assign capture = (READ_LATENCY == 0) ? o_fifo_pop : inflight;

    // Skid buffer storage, pointers and occupancy. Clear overrides any
    // capture or retire in the same cycle, so a word still in flight is lost.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_mem[0] <= '0;
            buf_mem[1] <= '0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            inflight   <= 1'b0;
        end else if (i_clear) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            count      <= 2'd0;
            inflight   <= 1'b0;
        end else begin
            if (capture) begin
                buf_mem[wr_ptr] <= i_fifo_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (fire) begin
                rd_ptr <= ~rd_ptr;
            end
            count    <= count + {1'b0, capture} - {1'b0, fire};
            inflight <= (READ_LATENCY == 1) & o_fifo_pop;
        end
    end

    // The output word comes straight from a buffer register, never from
    // i_fifo_data, so it holds steady while the consumer stalls.
    assign o_valid = (count != 2'd0);
    assign o_data  = buf_mem[rd_ptr];
    assign o_level = count;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader. Two instances are driven: one with registered
// FIFO data and one with show-ahead data. Each instance is fed from a small
// FIFO model. Every word pushed into a model is also queued as expected
// output. A monitor retires the expected words as the DUT hands words out.
module tb_fifo_stream_reader;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    logic         clr1, empty1, pop1, valid1, ready1;
    logic [W-1:0] fdata1 = '0;
    logic [W-1:0] data1;
    logic [1:0]   level1;

    logic         clr0, empty0, pop0, valid0, ready0;
    logic [W-1:0] fdata0, data0;
    logic [1:0]   level0;

    int n_total = 0;
    int n_bad   = 0;
    int npop1   = 0;

    logic [W-1:0] exp1[$];
    logic [W-1:0] exp0[$];
    logic [W-1:0] fmem1 [256];
    logic [W-1:0] fmem0 [256];
    logic [7:0]   head1 = 8'd0, tail1 = 8'd0;
    logic [7:0]   head0 = 8'd0, tail0 = 8'd0;

    always #5 clk = ~clk;

    fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(1)) dut1 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clr1),
        .i_fifo_empty (empty1),
        .o_fifo_pop   (pop1),
        .i_fifo_data  (fdata1),
        .o_valid      (valid1),
        .i_ready      (ready1),
        .o_data       (data1),
        .o_level      (level1)
    );

    fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(0)) dut0 (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_clear      (clr0),
        .i_fifo_empty (empty0),
        .o_fifo_pop   (pop0),
        .i_fifo_data  (fdata0),
        .o_valid      (valid0),
        .i_ready      (ready0),
        .o_data       (data0),
        .o_level      (level0)
    );

    // FIFO models: the registered one returns data the cycle after a pop,
    // and the show-ahead one presents its head word at all times.
    assign empty1 = (head1 == tail1);
    assign empty0 = (head0 == tail0);
    assign fdata0 = fmem0[head0];

    always @(posedge clk) begin
        if (pop1) begin
            fdata1 <= fmem1[head1];
            head1  <= head1 + 8'd1;
        end
        if (pop0) begin
            head0 <= head0 + 8'd1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Output monitor: each accepted word must be the oldest word still expected.
    always @(negedge clk) begin
        if (rst_n && pop1) npop1++;
        if (rst_n && !clr1 && valid1 && ready1) begin
            if (exp1.size() == 0) check("extra1", 32'(data1), 32'hFFFF_FFFF);
            else                  check("out1", 32'(data1), 32'(exp1.pop_front()));
        end
        if (rst_n && !clr0 && valid0 && ready0) begin
            if (exp0.size() == 0) check("extra0", 32'(data0), 32'hFFFF_FFFF);
            else                  check("out0", 32'(data0), 32'(exp0.pop_front()));
        end
    end

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic obs();
        @(negedge clk);
    endtask

    task automatic push1(input logic [W-1:0] w);
        fmem1[tail1] = w;
        tail1 = tail1 + 8'd1;
        exp1.push_back(w);
    endtask

    task automatic push0(input logic [W-1:0] w);
        fmem0[tail0] = w;
        tail0 = tail0 + 8'd1;
        exp0.push_back(w);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, last, nv, p0;
        logic         hold;
        logic [W-1:0] hdata;

        rst_n  = 1'b0;
        clr1   = 1'b0;
        clr0   = 1'b0;
        ready1 = 1'b1;
        ready0 = 1'b1;
        for (int i = 0; i < 8; i++) push1(8'(8'h10 + i));
        #1;
        check("rst_valid", 32'(valid1), 32'd0);
        check("rst_level", 32'(level1), 32'd0);
        check("rst_data", 32'(data1), 32'd0);
        check("rst_pop", 32'(pop1), 32'd0);

        // Streaming with ready held high.
        drive_edge();
        rst_n = 1'b1;
        first = -1;
        last  = -1;
        nv    = 0;
        for (int i = 0; i < 12; i++) begin
            obs();
            if (valid1) begin
                if (first < 0) first = i;
                last = i;
                nv++;
            end
        end
        check("first_valid", 32'(first), 32'd2);
        check("stream_nvalid", 32'(nv), 32'd8);
        check("stream_nogap", 32'(last - first + 1), 32'd8);
        drive_edge();
        check("stream_npop", 32'(npop1), 32'd8);
        check("stream_drain", 32'(exp1.size()), 32'd0);

        // Backpressure: buffer fills to two and popping stops.
        ready1 = 1'b0;
        p0 = npop1;
        for (int i = 0; i < 6; i++) push1(8'(8'h20 + i));
        for (int i = 0; i < 5; i++) obs();
        check("bp_level", 32'(level1), 32'd2);
        check("bp_pop", 32'(pop1), 32'd0);
        check("bp_data", 32'(data1), 32'h20);
        check("bp_valid", 32'(valid1), 32'd1);
        check("bp_npop", 32'(npop1 - p0), 32'd2);
        drive_edge();
        ready1 = 1'b1;
        nv = 0;
        for (int i = 0; i < 6; i++) begin
            obs();
            if (valid1) nv++;
        end
        check("bp_burst", 32'(nv), 32'd6);
        drive_edge();
        check("bp_drain", 32'(exp1.size()), 32'd0);

        // Alternating ready.
        for (int i = 0; i < 16; i++) push1(8'(8'h30 + i));
        hold  = 1'b0;
        hdata = '0;
        for (int i = 0; i < 48; i++) begin
            ready1 = (i % 2 == 0);
            obs();
            if (hold) check("alt_hold", 32'({valid1, data1}), 32'({1'b1, hdata}));
            check("alt_level_max", 32'(level1 <= 2'd2), 32'd1);
            hold  = valid1 & ~ready1;
            hdata = data1;
            drive_edge();
        end
        ready1 = 1'b1;
        check("alt_drain", 32'(exp1.size()), 32'd0);

        // Clear while a popped word is still on its way back.
        push1(8'h40);
        push1(8'h41);
        obs();
        check("clr_pop_before", 32'(pop1), 32'd1);
        drive_edge();
        clr1 = 1'b1;
        exp1.delete();
        obs();
        check("clr_pop_during", 32'(pop1), 32'd0);
        drive_edge();
        clr1  = 1'b0;
        tail1 = head1;
        obs();
        check("clr_valid", 32'(valid1), 32'd0);
        check("clr_level", 32'(level1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            obs();
            check("clr_dropped", 32'(valid1), 32'd0);
        end
        drive_edge();
        for (int i = 0; i < 3; i++) push1(8'(8'h50 + i));
        for (int i = 0; i < 8; i++) obs();
        drive_edge();
        check("clr_restart_drain", 32'(exp1.size()), 32'd0);

        // Show-ahead FIFO: single word, then empty.
        push0(8'hA5);
        obs();
        check("sa_pop", 32'(pop0), 32'd1);
        check("sa_valid_early", 32'(valid0), 32'd0);
        drive_edge();
        obs();
        check("sa_valid", 32'(valid0), 32'd1);
        check("sa_data", 32'(data0), 32'hA5);
        check("sa_pop_empty", 32'(pop0), 32'd0);
        drive_edge();
        obs();
        check("sa_valid_after", 32'(valid0), 32'd0);
        check("sa_pop_idle", 32'(pop0), 32'd0);
        drive_edge();
        for (int i = 0; i < 4; i++) push0(8'(8'hB0 + i));
        for (int i = 0; i < 6; i++) obs();
        drive_edge();
        check("sa_drain", 32'(exp0.size()), 32'd0);

        // Asynchronous reset with a full buffer.
        ready1 = 1'b0;
        for (int i = 0; i < 4; i++) push1(8'(8'h60 + i));
        for (int i = 0; i < 5; i++) obs();
        check("ar_level_before", 32'(level1), 32'd2);
        drive_edge();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(valid1), 32'd0);
        check("ar_level", 32'(level1), 32'd0);
        check("ar_data", 32'(data1), 32'd0);
        check("ar_pop", 32'(pop1), 32'd0);
        exp1.delete();
        tail1 = head1;
        drive_edge();
        rst_n  = 1'b1;
        ready1 = 1'b1;
        for (int i = 0; i < 4; i++) push1(8'(8'h70 + i));
        for (int i = 0; i < 8; i++) obs();
        drive_edge();
        check("ar_restart_drain", 32'(exp1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
